// File: rtl/fft_frame_loader.sv
// Collects four signed audio samples into a frame, hands the frame to a 4-point FFT
// with a start/done handshake, and keeps frame, drop and timeout statistics.
module fft_frame_loader #(
    parameter int SAMPLE_W = 16,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                sample_ready,
    output logic                fft_start,
    input  logic                fft_done,
    output logic [31:0]         frame0,
    output logic [31:0]         frame1,
    output logic [31:0]         frame2,
    output logic [31:0]         frame3,
    output logic [15:0]         frame_count,
    output logic [7:0]          drop_count,
    output logic                timeout_err,
    output logic [1:0]          dbg_state
);

    // Handshake: a sample transfers on a posedge where sample_valid && sample_ready;
    // sample_valid with sample_ready low is a drop and never touches the frame.

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        LAUNCH  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fft_start_q, fft_start_d;
    logic [31:0]       frame_q [4];
    logic [31:0]       frame_d [4];
    logic [15:0]       frame_count_q, frame_count_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic              timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        cnt_d         = cnt_q;
        fft_start_d   = fft_start_q;
        frame_d       = frame_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            FILL: begin
                if (sample_valid) begin
                    frame_d[wr_idx_q] = 32'(signed'(sample_in));
                    wr_idx_d          = wr_idx_q + 2'd1;
                    if (wr_idx_q == 2'd3) begin
                        wr_idx_d    = 2'd0;
                        fft_start_d = 1'b1;
                        state_d     = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // done wins over timeout when both land on the same edge
                if (fft_done) begin
                    fft_start_d   = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    cnt_d         = '0;
                    state_d       = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    fft_start_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!fft_done) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d     = FILL;
                fft_start_d = 1'b0;
            end
        endcase

        if (sample_valid && (state_q != FILL) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            wr_idx_q      <= 2'd0;
            cnt_q         <= '0;
            fft_start_q   <= 1'b0;
            frame_q       <= '{default: 32'd0};
            frame_count_q <= 16'd0;
            drop_count_q  <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            cnt_q         <= cnt_d;
            fft_start_q   <= fft_start_d;
            frame_q       <= frame_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sample_ready = (state_q == FILL);
    assign fft_start    = fft_start_q;
    assign frame0       = frame_q[0];
    assign frame1       = frame_q[1];
    assign frame2       = frame_q[2];
    assign frame3       = frame_q[3];
    assign frame_count  = frame_count_q;
    assign drop_count   = drop_count_q;
    assign timeout_err  = timeout_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: scenario tasks with a frame-level reference model
// (accepted-sample queue, expected counters) checked after each clock edge.
module tb_fft_frame_loader;

    localparam int SAMPLE_W = 16;
    localparam int TIMEOUT  = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_ready;
    logic                fft_start;
    logic                fft_done;
    logic [31:0]         frame0, frame1, frame2, frame3;
    logic [15:0]         frame_count;
    logic [7:0]          drop_count;
    logic                timeout_err;
    logic [1:0]          dbg_state;

    always #5 clk = ~clk;

    fft_frame_loader #(.SAMPLE_W(SAMPLE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .frame0       (frame0),
        .frame1       (frame1),
        .frame2       (frame2),
        .frame3       (frame3),
        .frame_count  (frame_count),
        .drop_count   (drop_count),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    logic [31:0] fr [4];
    assign fr[0] = frame0;
    assign fr[1] = frame1;
    assign fr[2] = frame2;
    assign fr[3] = frame3;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_frame [4];
    logic [15:0] exp_fc;
    logic [7:0]  exp_drop;
    logic        exp_to;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_drop();
        if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        fft_done     = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_frame[k] = 32'd0;
        exp_fc   = 16'd0;
        exp_drop = 8'd0;
        exp_to   = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // One complete frame: 4 accepts with random gaps, done after d start-high cycles
    // (d > TIMEOUT means never), done held r extra cycles, noise = % valid while busy.
    task automatic drive_frame(input logic [15:0] smp [4], input int gap_max,
                               input int d, input int r, input int noise);
        int hc, steps, exp_hc, rr;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = $urandom_range(0, gap_max);
            repeat (n) begin
                sample_valid = 1'b0;
                sample_in    = 16'($urandom);
                tick();
                total++;
                if ({sample_ready, fft_start} !== 2'b10) begin
                    bad++;
                    $display("FAIL fill_idle: ready,start=%b exp 10", {sample_ready, fft_start});
                end
            end
            sample_valid = 1'b1;
            sample_in    = smp[i];
            exp_q.push_back(32'(signed'(smp[i])));
            total++;
            if (sample_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready: ready=%b exp 1", sample_ready);
            end
            tick();
        end
        sample_valid = 1'b0;
        for (int k = 0; k < 4; k++) exp_frame[k] = exp_q.pop_front();
        total++;
        if ({fft_start, sample_ready} !== 2'b10) begin
            bad++;
            $display("FAIL launch_entry: start,ready=%b exp 10", {fft_start, sample_ready});
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (fr[k] !== exp_frame[k]) begin
                bad++;
                $display("FAIL frame%0d: got %h exp %h", k, fr[k], exp_frame[k]);
            end
        end

        hc    = 1;
        steps = 0;
        while (fft_start === 1'b1 && steps < TIMEOUT + 4) begin
            fft_done     = (hc >= d);
            sample_valid = ($urandom_range(0, 99) < noise);
            if (sample_valid) model_drop();
            tick();
            steps++;
            if (fft_start === 1'b1) hc++;
        end
        exp_hc = (d <= TIMEOUT) ? d : TIMEOUT;
        if (d <= TIMEOUT) exp_fc = exp_fc + 16'd1;
        else exp_to = 1'b1;
        total++;
        if (steps >= TIMEOUT + 4 || hc != exp_hc) begin
            bad++;
            $display("FAIL start_len: high %0d cycles exp %0d (steps %0d)", hc, exp_hc, steps);
        end
        total++;
        if (frame_count !== exp_fc || timeout_err !== exp_to || drop_count !== exp_drop) begin
            bad++;
            $display("FAIL launch_stats: fc=%h to=%b drop=%h exp fc=%h to=%b drop=%h",
                     frame_count, timeout_err, drop_count, exp_fc, exp_to, exp_drop);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (fr[k] !== exp_frame[k]) begin
                bad++;
                $display("FAIL hold_frame%0d: got %h exp %h", k, fr[k], exp_frame[k]);
            end
        end

        rr = (d <= TIMEOUT) ? r : 0;
        repeat (rr) begin
            fft_done     = 1'b1;
            sample_valid = ($urandom_range(0, 99) < noise);
            if (sample_valid) model_drop();
            tick();
            total++;
            if ({sample_ready, fft_start} !== 2'b00) begin
                bad++;
                $display("FAIL release_hold: ready,start=%b exp 00", {sample_ready, fft_start});
            end
        end
        fft_done     = 1'b0;
        sample_valid = ($urandom_range(0, 99) < noise);
        if (sample_valid) model_drop();
        tick();
        sample_valid = 1'b0;
        total++;
        if ({sample_ready, fft_start} !== 2'b10 || drop_count !== exp_drop) begin
            bad++;
            $display("FAIL release_exit: ready,start=%b drop=%h exp 10 drop=%h",
                     {sample_ready, fft_start}, drop_count, exp_drop);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({fft_start, frame0, frame1, frame2, frame3, frame_count, drop_count, timeout_err} !== '0
            || sample_ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: start=%b fc=%h drop=%h to=%b ready=%b st=%0d exp all 0, ready 1",
                     fft_start, frame_count, drop_count, timeout_err, sample_ready, dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [15:0] s [4];
        do_reset();
        s[0] = 16'sd1; s[1] = 16'sd2; s[2] = -16'sd1; s[3] = 16'h8000;
        drive_frame(s, 0, 3, 1, 0);
        total++;
        if (frame0 !== 32'h1 || frame1 !== 32'h2 || frame2 !== 32'hFFFF_FFFF || frame3 !== 32'hFFFF_8000) begin
            bad++;
            $display("FAIL basic_frame: %h %h %h %h exp 1 2 ffffffff ffff8000",
                     frame0, frame1, frame2, frame3);
        end
        total++;
        if (frame_count !== 16'd1) begin
            bad++;
            $display("FAIL basic_count: got %h exp 0001", frame_count);
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_in    = 16'($urandom);
            exp_q.push_back(32'(signed'(sample_in)));
            tick();
        end
        for (int k = 0; k < 4; k++) exp_frame[k] = exp_q.pop_front();
        repeat (5) tick();
        total++;
        if (drop_count !== 8'd5 || fft_start !== 1'b1) begin
            bad++;
            $display("FAIL drop_five: drop=%0d start=%b exp 5 1", drop_count, fft_start);
        end
        fft_done = 1'b1;
        repeat (300) tick();
        total++;
        if (drop_count !== 8'hFF || frame_count !== 16'd1 || sample_ready !== 1'b0) begin
            bad++;
            $display("FAIL drop_sat: drop=%h fc=%h ready=%b exp ff 0001 0",
                     drop_count, frame_count, sample_ready);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (fr[k] !== exp_frame[k]) begin
                bad++;
                $display("FAIL drop_frame%0d: got %h exp %h", k, fr[k], exp_frame[k]);
            end
        end
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        tick();
        total++;
        if (sample_ready !== 1'b1) begin
            bad++;
            $display("FAIL drop_exit: ready=%b exp 1", sample_ready);
        end
        exp_drop = 8'hFF;
        exp_fc   = 16'd1;
    endtask

    task automatic test_timeout();
        logic [15:0] s [4];
        do_reset();
        for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
        drive_frame(s, 1, TIMEOUT + 5, 0, 0);
        for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
        drive_frame(s, 2, 2, 0, 50);
        total++;
        if (timeout_err !== 1'b1 || frame_count !== 16'd1) begin
            bad++;
            $display("FAIL timeout_sticky: to=%b fc=%h exp 1 0001", timeout_err, frame_count);
        end
    endtask

    task automatic test_reset_mid_launch();
        logic [15:0] s [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_in    = 16'($urandom);
            tick();
        end
        repeat (2) tick();
        sample_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({fft_start, frame0, frame1, frame2, frame3, frame_count, drop_count, timeout_err} !== '0
            || sample_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: start=%b f0=%h fc=%h drop=%h to=%b ready=%b exp all 0, ready 1",
                     fft_start, frame0, frame_count, drop_count, timeout_err, sample_ready);
        end
        do_reset();
        for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
        drive_frame(s, 0, 2, 0, 0);
    endtask

    task automatic test_random();
        logic [15:0] s [4];
        do_reset();
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
            drive_frame(s, 3, $urandom_range(1, TIMEOUT + 3), $urandom_range(0, 2), 30);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] s [4];
        do_reset();
        tick();
        dut.frame_count_q = 16'hFFFE;
        exp_fc            = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
            drive_frame(s, 1, 1, 0, 0);
        end
        total++;
        if (frame_count !== 16'd0 || timeout_err !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap: fc=%h to=%b drop=%h exp 0000 0 00", frame_count, timeout_err, drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_timeout();
        test_reset_mid_launch();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
